// File: rtl/ifstage_pkg.sv
// ifstage_pkg
//   Shared definitions for the instruction-fetch prefetch stage: default
//   parameter values and the field widths of one prefetch-buffer entry
//   (fetch address + instruction word).
package ifstage_pkg;

   localparam int unsigned ADDR_W_DEF   = 32;
   localparam int unsigned DATA_W_DEF   = 32;
   localparam int unsigned DEPTH_DEF    = 4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int unsigned PC_STEP_DEF  = 4;

   // Field widths of a buffer entry at the default configuration.
   localparam int unsigned ENTRY_PC_W    = ADDR_W_DEF;
   localparam int unsigned ENTRY_INSTR_W = DATA_W_DEF;

endpackage

// File: rtl/ifstage_prefetch_fifo.sv
// fetch_fifo
//   Prefetch buffer holding {PC, instruction} entries in arrival order.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     flush               discard every entry (wins over push/pop)
//     push, push_pc,
//     push_instr          write one entry at the tail
//     pop                 remove the head entry (ignored when empty)
//     head_pc, head_instr head entry, forced to zero when empty
//     full, empty, count  occupancy status
module fetch_fifo
   import ifstage_pkg::*;
#(
   parameter int unsigned DEPTH   = DEPTH_DEF,
   parameter int unsigned PC_W    = ENTRY_PC_W,
   parameter int unsigned INSTR_W = ENTRY_INSTR_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [PC_W-1:0]          push_pc,
   input  logic [INSTR_W-1:0]       push_instr,
   input  logic                     pop,
   output logic [PC_W-1:0]          head_pc,
   output logic [INSTR_W-1:0]       head_instr,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PC_W-1:0]    mem_pc    [DEPTH];
   logic [INSTR_W-1:0] mem_instr [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               wr_en;
   logic               rd_en;

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));
   assign rd_en = pop & ~empty;
   // A full buffer still accepts a write when the head leaves the same cycle.
   assign wr_en = push & ~flush & (~full | rd_en);

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

   // NOTE: the storage array has no reset; entries are only ever read when
   // count marks them valid, so resetting them would add logic for nothing.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_pc[wr_ptr]    <= push_pc;
         mem_instr[wr_ptr] <= push_instr;
      end
   end

   // Zero the head when empty so stale storage never reaches the outputs.
   assign head_pc    = empty ? '0 : mem_pc[rd_ptr];
   assign head_instr = empty ? '0 : mem_instr[rd_ptr];

endmodule

// File: rtl/ifstage_prefetch.sv
// ifstage_prefetch
//   Instruction-fetch stage with a small prefetch buffer. Issues sequential
//   reads to an instruction memory with one-cycle read latency, buffers the
//   returned words with their PCs, and presents them to a valid/ready
//   consumer. A redirect flushes the buffer and restarts fetch at a new PC.
//   Ports:
//     Clk, Reset          clock, asynchronous active-low reset
//     PC_Immed, PC_sel    redirect target and redirect request
//     PC_LdEn             fetch enable (gates new requests only)
//     Imem_Req, Imem_Addr read request to instruction memory
//     Imem_Rdata          read data, one cycle after the request
//     Instr, Instr_PC,
//     Instr_Valid         head-of-buffer instruction to the consumer
//     Instr_Ready         consumer accepts the head entry
module ifstage_prefetch
   import ifstage_pkg::*;
#(
   parameter int unsigned            ADDR_W   = ADDR_W_DEF,
   parameter int unsigned            DATA_W   = DATA_W_DEF,
   parameter int unsigned            DEPTH    = DEPTH_DEF,
   parameter logic [ADDR_W-1:0]      RESET_PC = ADDR_W'(RESET_PC_DEF),
   parameter int unsigned            PC_STEP  = PC_STEP_DEF
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] PC_Immed,
   input  logic              PC_sel,
   input  logic              PC_LdEn,
   output logic              Imem_Req,
   output logic [ADDR_W-1:0] Imem_Addr,
   input  logic [DATA_W-1:0] Imem_Rdata,
   output logic [DATA_W-1:0] Instr,
   output logic [ADDR_W-1:0] Instr_PC,
   output logic              Instr_Valid,
   input  logic              Instr_Ready
);

   localparam int unsigned       CNT_W      = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0]    OCC_LIMIT  = (CNT_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
   // Clears the low log2(PC_STEP) bits of a redirect target.
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(PC_STEP - 1);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] req_pc;     // PC of the request whose data arrives now
   logic              inflight;   // a response is on Imem_Rdata this cycle
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic [CNT_W:0]    occupancy;
   logic              issue;
   logic              push;

   // Credit covers both buffered entries and the response still in flight,
   // so a response always has a free slot when it lands.
   assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

   // Reset appears here so the request drops the instant Reset falls; a
   // redirect cycle issues nothing because the target is loaded at its end.
   assign issue     = Reset & PC_LdEn & ~PC_sel & ~full & (occupancy < OCC_LIMIT);
   assign Imem_Req  = issue;
   assign Imem_Addr = fetch_pc;

   // A response landing in a redirect cycle belongs to the old stream.
   assign push = inflight & ~PC_sel;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) req_pc <= fetch_pc;
         if (PC_sel)     fetch_pc <= PC_Immed & ALIGN_MASK;
         else if (issue) fetch_pc <= fetch_pc + STEP;
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .PC_W    (ADDR_W),
      .INSTR_W (DATA_W)
   ) u_fifo (
      .clk        (Clk),
      .rst_n      (Reset),
      .flush      (PC_sel),
      .push       (push),
      .push_pc    (req_pc),
      .push_instr (Imem_Rdata),
      .pop        (Instr_Ready),
      .head_pc    (Instr_PC),
      .head_instr (Instr),
      .full       (full),
      .empty      (empty),
      .count      (count)
   );

   assign Instr_Valid = ~empty;

endmodule

// File: tb/tb_ifstage_prefetch.sv
// tb_ifstage_prefetch
//   Directed bench for ifstage_prefetch at default parameters. A queue-based
//   model of the fetch stream is compared against the DUT at every negative
//   clock edge; directed phases add hand-computed literal expectations.
module tb_ifstage_prefetch;
   import ifstage_pkg::*;

   localparam int unsigned DEPTH = DEPTH_DEF;

   logic        Clk;
   logic        Reset;
   logic [31:0] PC_Immed;
   logic        PC_sel;
   logic        PC_LdEn;
   logic        Imem_Req;
   logic [31:0] Imem_Addr;
   logic [31:0] Imem_Rdata;
   logic [31:0] Instr;
   logic [31:0] Instr_PC;
   logic        Instr_Valid;
   logic        Instr_Ready;

   int checks = 0;
   int errors = 0;

   ifstage_prefetch dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .PC_Immed    (PC_Immed),
      .PC_sel      (PC_sel),
      .PC_LdEn     (PC_LdEn),
      .Imem_Req    (Imem_Req),
      .Imem_Addr   (Imem_Addr),
      .Imem_Rdata  (Imem_Rdata),
      .Instr       (Instr),
      .Instr_PC    (Instr_PC),
      .Instr_Valid (Instr_Valid),
      .Instr_Ready (Instr_Ready)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #90000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction memory: data for a request seen in cycle k is driven during
   // cycle k+1; garbage otherwise so an unwanted capture is visible.
   initial begin
      logic        pend;
      logic [31:0] paddr;
      Imem_Rdata = 32'hDEAD_BEEF;
      forever begin
         @(negedge Clk);
         pend  = Imem_Req;
         paddr = Imem_Addr;
         @(posedge Clk);
         #1;
         Imem_Rdata = pend ? instr_of(paddr) : 32'hDEAD_BEEF;
      end
   end

   // Stream model: buffered PCs in a queue plus at most one outstanding read.
   logic [31:0] m_buf [$];
   bit          m_infl;
   logic [31:0] m_infl_pc;
   logic [31:0] m_fpc;

   initial begin
      bit exp_req;
      bit exp_valid;
      m_infl    = 1'b0;
      m_infl_pc = '0;
      m_fpc     = RESET_PC_DEF;
      forever begin
         @(negedge Clk);
         if (!Reset) begin
            m_buf.delete();
            m_infl = 1'b0;
            m_fpc  = RESET_PC_DEF;
            check("m_rst_req",   Imem_Req,    0);
            check("m_rst_valid", Instr_Valid, 0);
            check("m_rst_instr", Instr,       0);
            check("m_rst_pc",    Instr_PC,    0);
         end else begin
            exp_valid = (m_buf.size() > 0);
            exp_req   = PC_LdEn && !PC_sel && ((m_buf.size() + int'(m_infl)) < DEPTH);
            check("m_req",   Imem_Req,    exp_req);
            check("m_valid", Instr_Valid, exp_valid);
            if (exp_req) check("m_addr", Imem_Addr, m_fpc);
            if (exp_valid) begin
               check("m_pc",    Instr_PC, m_buf[0]);
               check("m_instr", Instr,    instr_of(m_buf[0]));
            end
            if (exp_valid && Instr_Ready) void'(m_buf.pop_front());
            if (PC_sel) begin
               m_buf.delete();
               m_infl = 1'b0;
               m_fpc  = PC_Immed & ~32'(PC_STEP_DEF - 1);
            end else begin
               if (m_infl) m_buf.push_back(m_infl_pc);
               m_infl    = exp_req;
               m_infl_pc = m_fpc;
               if (exp_req) m_fpc = m_fpc + 32'(PC_STEP_DEF);
            end
            if (m_buf.size() > DEPTH) check("m_overflow", m_buf.size(), DEPTH);
         end
      end
   end

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic redirect(input logic [31:0] tgt);
      PC_sel   = 1'b1;
      PC_Immed = tgt;
      @(negedge Clk);
      check("redir_no_req", Imem_Req, 0);
      cyc();
      PC_sel = 1'b0;
   endtask

   logic [31:0] wrap_seq [3];

   initial begin
      wrap_seq[0] = 32'hFFFF_FFF8;
      wrap_seq[1] = 32'hFFFF_FFFC;
      wrap_seq[2] = 32'h0000_0000;
      Reset       = 1'b0;
      PC_Immed    = '0;
      PC_sel      = 1'b0;
      PC_LdEn     = 1'b1;
      Instr_Ready = 1'b1;

      // Reset state, before any clock edge.
      #2;
      check("rst_req",   Imem_Req,    0);
      check("rst_valid", Instr_Valid, 0);
      check("rst_instr", Instr,       0);
      check("rst_pc",    Instr_PC,    0);
      cyc();
      cyc();

      // Streaming from reset: addresses 0,4,8,12 then PCs 0,4,8,12 from cycle 2.
      Reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         if (i < 4) begin
            check("t1_req",  Imem_Req,  1);
            check("t1_addr", Imem_Addr, 32'(4 * i));
         end
         if (i >= 2) begin
            check("t1_valid", Instr_Valid, 1);
            check("t1_pc",    Instr_PC,    32'(4 * (i - 2)));
         end
         cyc();
      end

      // Back-pressure from reset: four requests fill the buffer, head holds.
      Reset       = 1'b0;
      Instr_Ready = 1'b0;
      cyc();
      Reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         check("t2_req", Imem_Req, (i < 4));
         if (i < 4) check("t2_addr", Imem_Addr, 32'(4 * i));
         if (i >= 2) begin
            check("t2_valid", Instr_Valid, 1);
            check("t2_pc",    Instr_PC,    0);
         end
         cyc();
      end
      Instr_Ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         check("t2_drain_valid", Instr_Valid, 1);
         check("t2_drain_pc",    Instr_PC,    32'(4 * i));
         cyc();
      end

      // Redirect to 0x103 with a full buffer.
      Instr_Ready = 1'b0;
      repeat (6) cyc();
      @(negedge Clk);
      check("t3_full_req", Imem_Req,    0);
      check("t3_head_pc",  Instr_PC,    32'h18);
      cyc();
      Instr_Ready = 1'b0;
      redirect(32'h0000_0103);
      Instr_Ready = 1'b1;
      @(negedge Clk);
      check("t3_valid0", Instr_Valid, 0);
      check("t3_addr0",  Imem_Addr,   32'h100);
      cyc();
      @(negedge Clk);
      check("t3_valid1", Instr_Valid, 0);
      check("t3_addr1",  Imem_Addr,   32'h104);
      cyc();
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("t3_valid", Instr_Valid, 1);
         check("t3_pc",    Instr_PC,    32'h100 + 32'(4 * i));
         cyc();
      end

      // Redirect coinciding with a transfer of the head (0x10C).
      @(negedge Clk);
      check("t3b_pre_pc", Instr_PC, 32'h10C);
      cyc();
      redirect(32'h0000_0200);
      @(negedge Clk);
      check("t3b_valid0", Instr_Valid, 0);
      check("t3b_addr0",  Imem_Addr,   32'h200);
      cyc();
      cyc();
      @(negedge Clk);
      check("t3b_pc", Instr_PC, 32'h200);
      cyc();

      // Redirect near the top of the address space: PCs wrap to zero.
      redirect(32'hFFFF_FFF8);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         if (i < 3) check("t4_addr", Imem_Addr, wrap_seq[i]);
         if (i >= 2) begin
            check("t4_valid", Instr_Valid, 1);
            check("t4_pc",    Instr_PC,    wrap_seq[i - 2]);
         end
         cyc();
      end

      // Fetch enable low for three cycles mid-stream.
      redirect(32'h0000_1000);
      repeat (4) cyc();
      PC_LdEn = 1'b0;
      @(negedge Clk);
      check("t5_req0", Imem_Req, 0);
      check("t5_pc0",  Instr_PC, 32'h1008);
      cyc();
      @(negedge Clk);
      check("t5_req1", Imem_Req, 0);
      check("t5_pc1",  Instr_PC, 32'h100C);
      cyc();
      @(negedge Clk);
      check("t5_req2",   Imem_Req,    0);
      check("t5_valid2", Instr_Valid, 0);
      cyc();
      PC_LdEn = 1'b1;
      @(negedge Clk);
      check("t5_resume_addr", Imem_Addr, 32'h1010);
      cyc();
      cyc();
      @(negedge Clk);
      check("t5_resume_pc", Instr_PC, 32'h1010);
      cyc();

      // Asynchronous reset mid-stream, then restart at the reset PC.
      repeat (3) cyc();
      #2;
      Reset = 1'b0;
      #1;
      check("t6_async_req",   Imem_Req,    0);
      check("t6_async_valid", Instr_Valid, 0);
      check("t6_async_instr", Instr,       0);
      check("t6_async_pc",    Instr_PC,    0);
      cyc();
      cyc();
      Reset = 1'b1;
      @(negedge Clk);
      check("t6_restart_addr0", Imem_Addr, 32'h0);
      check("t6_restart_req0",  Imem_Req,  1);
      cyc();
      @(negedge Clk);
      check("t6_restart_addr1", Imem_Addr, 32'h4);
      cyc();
      @(negedge Clk);
      check("t6_restart_pc", Instr_PC, 32'h0);
      cyc();
      repeat (3) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
